// File: rtl/genius_seq_engine.sv
// Genius/Simon round engine: plays back a growing pattern prefix, checks the player's
// presses against it, enforces an inactivity timeout, keeps score and advances rounds.
module genius_seq_engine #(
  parameter int unsigned NUM_KEYS      = 4,
  parameter int unsigned MAX_ROUNDS    = 16,
  parameter int unsigned TIMEOUT_TICKS = 5,
  parameter int unsigned PTS_W         = 8,
  localparam int unsigned AW = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1,
  localparam int unsigned RW = $clog2(MAX_ROUNDS + 1)
) (
  input  logic                CLOCK_50,
  input  logic                R,
  input  logic                start,
  input  logic                tick,
  input  logic [NUM_KEYS-1:0] btn,
  output logic [AW-1:0]       seq_addr,
  input  logic [NUM_KEYS-1:0] seq_data,
  output logic [NUM_KEYS-1:0] leds,
  output logic [RW-1:0]       round,
  output logic [PTS_W-1:0]    points,
  output logic                end_FPGA,
  output logic                end_User,
  output logic                match,
  output logic                end_time,
  output logic                win,
  output logic                busy
);

  localparam int unsigned TW = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StShowOn,
    StShowOff,
    StUser,
    StRoundOk,
    StWin,
    StLose
  } state_e;

  state_e              r_state,    w_state_nxt;
  logic [AW-1:0]       r_idx,      w_idx_nxt;
  logic [RW-1:0]       r_round,    w_round_nxt;
  logic [PTS_W-1:0]    r_points,   w_points_nxt;
  logic [TW-1:0]       r_timer,    w_timer_nxt;
  logic                r_end_fpga, w_end_fpga_nxt;
  logic                r_end_time, w_end_time_nxt;
  logic [NUM_KEYS-1:0] r_btn_prev;

  logic                w_press;
  logic                w_last;
  logic [PTS_W:0]      w_sum;

  // A press is a rising edge from "no key held" to "some key held"; held keys never re-trigger.
  assign w_press = (btn != '0) && (r_btn_prev == '0);
  assign w_last  = (RW'(r_idx) == (r_round - RW'(1)));
  assign w_sum   = {1'b0, r_points} + (PTS_W + 1)'(r_round);

  always_ff @(posedge CLOCK_50) begin
    if (R) begin
      r_state    <= StIdle;
      r_idx      <= '0;
      r_round    <= '0;
      r_points   <= '0;
      r_timer    <= '0;
      r_end_fpga <= 1'b0;
      r_end_time <= 1'b0;
      r_btn_prev <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_round    <= w_round_nxt;
      r_points   <= w_points_nxt;
      r_timer    <= w_timer_nxt;
      r_end_fpga <= w_end_fpga_nxt;
      r_end_time <= w_end_time_nxt;
      r_btn_prev <= btn;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_round_nxt    = r_round;
    w_points_nxt   = r_points;
    w_timer_nxt    = r_timer;
    w_end_fpga_nxt = 1'b0;
    w_end_time_nxt = r_end_time;

    unique case (r_state)
      StIdle, StWin, StLose: begin
        if (start) begin
          w_state_nxt    = StShowOn;
          w_round_nxt    = RW'(1);
          w_idx_nxt      = '0;
          w_points_nxt   = '0;
          w_timer_nxt    = '0;
          w_end_time_nxt = 1'b0;
        end
      end

      StShowOn: begin
        if (tick) w_state_nxt = StShowOff;
      end

      StShowOff: begin
        if (tick) begin
          if (w_last) begin
            w_state_nxt    = StUser;
            w_idx_nxt      = '0;
            w_timer_nxt    = '0;
            w_end_fpga_nxt = 1'b1;
          end else begin
            w_state_nxt = StShowOn;
            w_idx_nxt   = r_idx + AW'(1);
          end
        end
      end

      StUser: begin
        if (w_press) begin
          if (btn == seq_data) begin
            w_timer_nxt = '0;
            if (w_last) w_state_nxt = StRoundOk;
            else        w_idx_nxt   = r_idx + AW'(1);
          end else begin
            w_state_nxt    = StLose;
            w_end_time_nxt = 1'b0;
          end
        end else if (tick) begin
          if ((r_timer + TW'(1)) == TW'(TIMEOUT_TICKS)) begin
            w_state_nxt    = StLose;
            w_end_time_nxt = 1'b1;
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
      end

      StRoundOk: begin
        w_points_nxt = w_sum[PTS_W] ? '1 : w_sum[PTS_W-1:0];
        if (r_round == RW'(MAX_ROUNDS)) begin
          w_state_nxt = StWin;
        end else begin
          w_state_nxt = StShowOn;
          w_round_nxt = r_round + RW'(1);
          w_idx_nxt   = '0;
        end
      end

      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    leds = '0;
    unique case (r_state)
      StShowOn: leds = seq_data;
      StUser:   leds = btn;
      StWin:    leds = '1;
      default:  leds = '0;
    endcase
  end

  assign seq_addr = r_idx;
  assign round    = r_round;
  assign points   = r_points;
  assign end_FPGA = r_end_fpga;
  assign end_User = (r_state == StRoundOk);
  assign match    = (r_state == StRoundOk);
  assign end_time = r_end_time;
  assign win      = (r_state == StWin);
  assign busy     = (r_state != StIdle) && (r_state != StWin) && (r_state != StLose);

endmodule

// File: tb/tb_genius_seq_engine.sv
// Directed bench: a default-size engine and a MAX_ROUNDS=2 engine share stimulus and a pattern ROM.
module tb_genius_seq_engine;

  logic       clk = 1'b0;
  logic       r_rst;
  logic       start;
  logic       tick;
  logic [3:0] btn;
  logic [3:0] rom [0:15];

  logic [3:0] addr_a;
  logic [3:0] data_a, leds_a;
  logic [4:0] round_a;
  logic [7:0] pts_a;
  logic       efpga_a, euser_a, match_a, etime_a, win_a, busy_a;

  logic [0:0] addr_b;
  logic [3:0] data_b, leds_b;
  logic [1:0] round_b;
  logic [7:0] pts_b;
  logic       efpga_b, euser_b, match_b, etime_b, win_b, busy_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign data_a = rom[addr_a];
  assign data_b = rom[{3'b000, addr_b}];

  genius_seq_engine dut (
    .CLOCK_50(clk), .R(r_rst), .start(start), .tick(tick), .btn(btn),
    .seq_addr(addr_a), .seq_data(data_a), .leds(leds_a), .round(round_a), .points(pts_a),
    .end_FPGA(efpga_a), .end_User(euser_a), .match(match_a), .end_time(etime_a),
    .win(win_a), .busy(busy_a)
  );

  genius_seq_engine #(.MAX_ROUNDS(2)) dut2 (
    .CLOCK_50(clk), .R(r_rst), .start(start), .tick(tick), .btn(btn),
    .seq_addr(addr_b), .seq_data(data_b), .leds(leds_b), .round(round_b), .points(pts_b),
    .end_FPGA(efpga_b), .end_User(euser_b), .match(match_b), .end_time(etime_b),
    .win(win_b), .busy(busy_b)
  );

  typedef struct packed {
    logic       start;
    logic       tick;
    logic [3:0] btn;
    logic [3:0] leds;
    int         rnd;
    int         pts;
    logic       efpga;
    logic       euser;
    logic       busy;
    logic       win2;
  } vec_t;

  vec_t tv [25];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    r_rst = 1'b1; start = 1'b0; tick = 1'b0; btn = 4'b0000;
    cyc();
    r_rst = 1'b0;
  endtask

  task automatic start_game();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Playback of an n-symbol round: one tick on, one tick off per symbol.
  task automatic show(input int n);
    tick = 1'b1;
    repeat (2 * n) cyc();
    tick = 1'b0;
    chk("end_FPGA after playback", 32'(efpga_a), 32'd1);
  endtask

  task automatic press(input logic [3:0] k);
    btn = k;
    cyc();
    btn = 4'b0000;
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 4'b1000;
    rom[0] = 4'b0001;
    rom[1] = 4'b0010;
    rom[2] = 4'b0100;

    //          st tk btn      leds     rnd pts ef eu bsy w2
    tv[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0001, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[1]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[2]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[3]  = '{1'b0, 1'b0, 4'b0001, 4'b0000, 1, 0, 1'b0, 1'b1, 1'b1, 1'b0};
    tv[4]  = '{1'b0, 1'b0, 4'b0001, 4'b0001, 2, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[5]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 2, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[6]  = '{1'b0, 1'b1, 4'b0000, 4'b0010, 2, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[7]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 2, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[8]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 2, 1, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[9]  = '{1'b0, 1'b0, 4'b0001, 4'b0001, 2, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[10] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 2, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[11] = '{1'b0, 1'b0, 4'b0010, 4'b0000, 2, 1, 1'b0, 1'b1, 1'b1, 1'b0};
    tv[12] = '{1'b0, 1'b0, 4'b0000, 4'b0001, 3, 3, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[13] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 3, 3, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[14] = '{1'b0, 1'b1, 4'b0000, 4'b0010, 3, 3, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[15] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 3, 3, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[16] = '{1'b0, 1'b1, 4'b0000, 4'b0100, 3, 3, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[17] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 3, 3, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[18] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 3, 3, 1'b1, 1'b0, 1'b1, 1'b1};
    tv[19] = '{1'b0, 1'b0, 4'b0001, 4'b0001, 3, 3, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[20] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 3, 3, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[21] = '{1'b0, 1'b0, 4'b0010, 4'b0010, 3, 3, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[22] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 3, 3, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[23] = '{1'b0, 1'b0, 4'b0100, 4'b0000, 3, 3, 1'b0, 1'b1, 1'b1, 1'b1};
    tv[24] = '{1'b0, 1'b0, 4'b0000, 4'b0001, 4, 6, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset state
    do_reset();
    chk("reset leds", 32'(leds_a), 32'd0);
    chk("reset round", 32'(round_a), 32'd0);
    chk("reset points", 32'(pts_a), 32'd0);
    chk("reset seq_addr", 32'(addr_a), 32'd0);
    chk("reset busy", 32'(busy_a), 32'd0);
    chk("reset win", 32'(win_a), 32'd0);
    chk("reset end_time", 32'(etime_a), 32'd0);
    chk("reset end_FPGA", 32'(efpga_a), 32'd0);

    // Three correct rounds, cycle by cycle; the MAX_ROUNDS=2 engine wins along the way
    for (int i = 0; i < 25; i++) begin
      start = tv[i].start;
      tick  = tv[i].tick;
      btn   = tv[i].btn;
      cyc();
      chk($sformatf("row%0d leds", i), 32'(leds_a), 32'(tv[i].leds));
      chk($sformatf("row%0d round", i), 32'(round_a), 32'(tv[i].rnd));
      chk($sformatf("row%0d points", i), 32'(pts_a), 32'(tv[i].pts));
      chk($sformatf("row%0d end_FPGA", i), 32'(efpga_a), 32'(tv[i].efpga));
      chk($sformatf("row%0d end_User", i), 32'(euser_a), 32'(tv[i].euser));
      chk($sformatf("row%0d match", i), 32'(match_a), 32'(tv[i].euser));
      chk($sformatf("row%0d busy", i), 32'(busy_a), 32'(tv[i].busy));
      chk($sformatf("row%0d win2", i), 32'(win_b), 32'(tv[i].win2));
    end
    btn = 4'b0000; tick = 1'b0;
    chk("win2 leds", 32'(leds_b), 32'd15);
    chk("win2 round", 32'(round_b), 32'd2);
    chk("win2 points", 32'(pts_b), 32'd3);
    chk("win2 busy", 32'(busy_b), 32'd0);

    // Start while busy is ignored; start in WIN restarts
    start_game();
    chk("busy start round", 32'(round_a), 32'd4);
    chk("busy start points", 32'(pts_a), 32'd6);
    chk("restart2 round", 32'(round_b), 32'd1);
    chk("restart2 points", 32'(pts_b), 32'd0);
    chk("restart2 win", 32'(win_b), 32'd0);

    // Wrong key in round 2
    do_reset();
    start_game();
    chk("start round", 32'(round_a), 32'd1);
    show(1);
    press(4'b0001);
    show(2);
    press(4'b0001);
    btn = 4'b1000;
    cyc();
    chk("wrong busy", 32'(busy_a), 32'd0);
    chk("wrong end_time", 32'(etime_a), 32'd0);
    chk("wrong points", 32'(pts_a), 32'd1);
    chk("wrong round", 32'(round_a), 32'd2);
    btn = 4'b0000; tick = 1'b1;
    repeat (3) cyc();
    tick = 1'b0;
    chk("lose frozen points", 32'(pts_a), 32'd1);
    chk("lose frozen busy", 32'(busy_a), 32'd0);
    chk("lose leds", 32'(leds_a), 32'd0);

    // Reset in mid-playback
    start_game();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    r_rst = 1'b1;
    cyc();
    r_rst = 1'b0;
    chk("midgame reset round", 32'(round_a), 32'd0);
    chk("midgame reset busy", 32'(busy_a), 32'd0);

    // Timeout after 5 idle ticks
    start_game();
    show(1);
    tick = 1'b1;
    repeat (4) cyc();
    chk("4 ticks still busy", 32'(busy_a), 32'd1);
    chk("4 ticks end_time", 32'(etime_a), 32'd0);
    cyc();
    tick = 1'b0;
    chk("timeout busy", 32'(busy_a), 32'd0);
    chk("timeout end_time", 32'(etime_a), 32'd1);
    chk("timeout round", 32'(round_a), 32'd1);

    // Press on the 5th tick wins over the timeout
    start_game();
    chk("restart clears end_time", 32'(etime_a), 32'd0);
    show(1);
    tick = 1'b1;
    repeat (4) cyc();
    btn = 4'b0001;
    cyc();
    tick = 1'b0;
    chk("press on tick end_User", 32'(euser_a), 32'd1);
    chk("press on tick end_time", 32'(etime_a), 32'd0);
    btn = 4'b0000;
    cyc();
    chk("press on tick points", 32'(pts_a), 32'd1);

    // Held key spanning two identical symbols counts once, then times out
    rom[1] = 4'b0001;
    do_reset();
    start_game();
    show(1);
    press(4'b0001);
    show(2);
    btn = 4'b0001;
    cyc();
    chk("hold first seq_addr", 32'(addr_a), 32'd1);
    repeat (3) cyc();
    chk("hold no retrigger addr", 32'(addr_a), 32'd1);
    chk("hold no end_User", 32'(euser_a), 32'd0);
    tick = 1'b1;
    repeat (5) cyc();
    tick = 1'b0;
    chk("hold timeout end_time", 32'(etime_a), 32'd1);
    chk("hold timeout busy", 32'(busy_a), 32'd0);
    chk("hold timeout points", 32'(pts_a), 32'd1);
    btn = 4'b0000;
    rom[1] = 4'b0010;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
